ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the companion of the host receiver. Sends one command byte to the mouse.
//  Sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit, device ACK.
//  Drives the open-drain PS/2 lines through active-high pull-low enables.
//  Gates the receiver through ps2_rx_en while busy, so the receiver never decodes host-driven frames.
// PARAMETERS
//  INHIBIT_CYCLES      5000    clk cycles ps2_clk held low before RTS (100 us @ 50 MHz)
//  RTS_CYCLES          100     clk cycles data low with clk still low, before releasing clk
//  FIRST_EDGE_TIMEOUT  750000  max clk cycles from clk release to first device falling edge (15 ms)
//  BIT_TIMEOUT         8191    max clk cycles between consecutive device falling edges
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  ps2_clk_in     in   1  raw PS/2 clock line (asynchronous)
//  ps2_data_in    in   1  raw PS/2 data line (asynchronous)
//  ps2_clk_oe     out  1  1 = pull PS/2 clock low; 0 = release
//  ps2_data_oe    out  1  1 = pull PS/2 data low; 0 = release
//  ps2_wr_en      in   1  write strobe; accepted only when ps2_tx_ready=1
//  ps2_wr_data    in   8  command byte, sampled on the accepted strobe
//  ps2_tx_ready   out  1  1 in IDLE only
//  ps2_tx_done    out  1  one-cycle pulse: byte sent and acknowledged
//  ps2_tx_err     out  1  one-cycle pulse: timeout or NACK
//  ps2_rx_en      out  1  receiver enable; equals ps2_tx_ready
// BEHAVIOUR
//  - Synchronisation: ps2_clk_in and ps2_data_in pass through 2-flop synchronisers.
//    Falling edge fe = prev synced clk & ~synced clk.
//  - Reset: state IDLE. clk_oe=0, data_oe=0, done=0, err=0, ready=1, rx_en=1. All counters cleared.
//  - Reset mid-frame: both lines are released on the cycle after rst. No done or err pulse.
//  - Outputs: ps2_clk_oe, ps2_data_oe, ps2_tx_done, ps2_tx_err are registered.
//  - Shift register: 10 bits, {1'b1 stop, ~^data odd parity, data[7:0]}. Loaded on accept.
//  - FSM states: IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE.
//  - IDLE
//    - ps2_wr_en & ready: load shift register; clk_oe=1; go to INHIBIT.
//    - ps2_wr_en in any other state is ignored; the byte is dropped.
//  - INHIBIT
//    - Hold clk_oe=1 for INHIBIT_CYCLES.
//    - Then set data_oe=1 (start bit) and go to RTS.
//  - RTS
//    - After RTS_CYCLES, set clk_oe=0 and load the timeout counter with FIRST_EDGE_TIMEOUT.
//    - Go to DATA with bit_cnt=0.
//  - DATA
//    - On each fe: data_oe = ~shift[0]; shift right; bit_cnt++; reload timeout with BIT_TIMEOUT.
//    - fe 1..8 drive D0..D7; fe 9 drives parity; fe 10 releases data (stop).
//    - After the 10th fe, go to ACK.
//  - ACK
//    - On the next fe (11th), sample synced data as the ACK bit (0 = ACK). Go to WAIT_IDLE.
//  - WAIT_IDLE
//    - Wait until synced clk=1 and data=1; timeout still armed.
//    - Then pulse done (or err if NACK was latched); go to IDLE.
//  - Timeout
//    - Counter decrements in DATA, ACK and WAIT_IDLE.
//    - Reaching 0: release both lines, pulse err, go to IDLE.
//    - fe and expiry in the same cycle: fe wins.
//  - Parity width: 8-bit XOR reduction, inverted. 0x00 gives parity 1.
//  - Latency from accept to first line activity: 1 cycle (clk_oe rises on the cycle after the accepted strobe).
// CONFIGURATION
//  PS2_TX_ACK_CHECK_EN
//    - Defined: ACK bit=1 (NACK) makes WAIT_IDLE end with an err pulse and no done pulse.
//    - Undefined: the ACK bit is ignored; a completed frame always gives done. Timeouts still give err.
// TESTING
//  1. Write 0xF4; device model clocks ~12 kHz and ACKs.
//     -> data on fe1..10 = 0,0,1,0,1,1,1,1,0,released; done=1 for 1 cycle; err=0.
//  2. Write 0x00 -> parity bit on fe9 = 1 (data_oe=0); done pulse; ready back to 1.
//  3. Second ps2_wr_en while in DATA -> ignored; only one frame on the wire; one done pulse.
//  4. Device never clocks after RTS -> err pulse FIRST_EDGE_TIMEOUT cycles after clk release;
//     clk_oe=data_oe=0; state IDLE.
//  5. ACK bit=1 on fe11 -> err pulse with PS2_TX_ACK_CHECK_EN, done pulse without it.
//  6. rst asserted at fe5 of DATA -> clk_oe=data_oe=0 next cycle; ready=1; no done or err pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device. The sequence is:
//   1. clock inhibit
//   2. request-to-send
//   3. 8 data bits, LSB first
//   4. odd parity bit
//   5. stop bit
//   6. device ACK
// The PS/2 lines are open-drain, so they are driven only through the
// active-high pull-low enables ps2_clk_oe and ps2_data_oe.
// Optional build macro PS2_TX_ACK_CHECK_EN: when defined, a NACK from the
// device ends the frame with an err pulse instead of a done pulse.
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int RTS_CYCLES         = 100,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int BIT_TIMEOUT        = 8191
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       ps2_wr_en,
  input  logic [7:0] ps2_wr_data,
  output logic       ps2_tx_ready,
  output logic       ps2_tx_done,
  output logic       ps2_tx_err,
  output logic       ps2_rx_en
);

  localparam int PH_MAX  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_W   = $clog2(PH_MAX + 1);
  localparam int TMO_MAX = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST  = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_FIRST = TMO_W'(FIRST_EDGE_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_BIT   = TMO_W'(BIT_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [9:0]         shift_q, shift_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmo_hit;
`ifdef PS2_TX_ACK_CHECK_EN
  logic               nack_q, nack_d;
`endif

  // Two-flop synchronisers; the lines idle high, so the flops reset to 1.
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fe;

  // Synchronise the raw PS/2 lines and keep the previous clock sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fe = clk_prev_q & ~clk_s2_q;

  // Control registers: state, counters, registered line enables and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q    <= nack_d;
`endif
    end
  end

  // Frame shift register; pure data path, so it is not reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Next-state logic: frame sequencing, bit shifting and timeout supervision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmo_hit   = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_d    = nack_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (ps2_wr_en) begin
          // Frame layout, LSB first: {stop, odd parity, data}.
          shift_d   = {1'b1, ~^ps2_wr_data, ps2_wr_data};
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          // Start bit: pull data low while the clock is still inhibited.
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RTS: begin
        if (cnt_q == RTS_LAST) begin
          clk_oe_d  = 1'b0;
          tmo_d     = TMO_FIRST;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (fe) begin
          // A device falling edge takes priority over a timeout expiring in the same cycle.
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = TMO_BIT;
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_ACK;
          end
        end else if (tmo_q <= TMO_ONE) begin
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end

      ST_ACK: begin
        if (fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
          nack_d = data_s2_q;
`endif
          tmo_d   = TMO_BIT;
          state_d = ST_WAIT_IDLE;
        end else if (tmo_q <= TMO_ONE) begin
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
`ifdef PS2_TX_ACK_CHECK_EN
          err_d  = nack_q;
          done_d = ~nack_q;
`else
          done_d = 1'b1;
`endif
          state_d = ST_IDLE;
        end else if (tmo_q <= TMO_ONE) begin
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Expiry abandons the frame: release both lines and report the error.
    if (tmo_hit) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign ps2_tx_done  = done_q;
  assign ps2_tx_err   = err_q;
  assign ps2_tx_ready = (state_q == ST_IDLE);
  assign ps2_rx_en    = ps2_tx_ready;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx.
// Behavioural PS/2 device model plus a scoreboard. Each issued write pushes
// its expected line frame and outcome; a monitor pops and compares them on
// every done/err pulse.
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 6;
  localparam int FET = 400;
  localparam int BT  = 120;
  localparam int H   = 10;

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit NACK_IS_ERR = 1'b1;
`else
  localparam bit NACK_IS_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_wr_en = 1'b0;
  logic [7:0] ps2_wr_data = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, ps2_tx_ready, ps2_tx_done, ps2_tx_err, ps2_rx_en;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       line_clk, line_data;

  assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign line_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS),
    .FIRST_EDGE_TIMEOUT(FET), .BIT_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(line_clk), .ps2_data_in(line_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .ps2_wr_en(ps2_wr_en), .ps2_wr_data(ps2_wr_data),
    .ps2_tx_ready(ps2_tx_ready), .ps2_tx_done(ps2_tx_done),
    .ps2_tx_err(ps2_tx_err), .ps2_rx_en(ps2_rx_en)
  );

  typedef struct {
    bit       has_frame;
    bit [9:0] frame;
    bit       is_err;
  } exp_t;

  exp_t     exp_q[$];
  bit [9:0] obs_q[$];
  int       n_chk  = 0;
  int       n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line levels the device should see after falling edges 1..10.
  // Bits 0-7 are the data, LSB first; bit 8 makes the count of ones odd;
  // bit 9 is the released stop level.
  function automatic bit [9:0] ref_frame(input bit [7:0] d);
    int ones = 0;
    bit [9:0] f;
    for (int i = 0; i < 8; i++) begin
      ones += int'(d[i]);
      f[i] = d[i];
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ps2_tx_done || ps2_tx_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, ps2_tx_done, ps2_tx_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("outcome_err", 32'(ps2_tx_err), 32'(e.is_err));
        check("outcome_done", 32'(ps2_tx_done), 32'(!e.is_err));
        check("end_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("end_data_oe", 32'(ps2_data_oe), 32'd0);
        check("end_ready", 32'(ps2_tx_ready), 32'd1);
        check("end_rx_en", 32'(ps2_rx_en), 32'd1);
        if (e.has_frame) begin
          if (obs_q.size() == 0) check("frame_seen", 32'd0, 32'd1);
          else check("frame_bits", 32'(obs_q.pop_front()), 32'(e.frame));
        end
      end
    end
  end

  task automatic host_write(input bit [7:0] d);
    int t = 0;
    while (!ps2_tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ps2_wr_data = d;
    ps2_wr_en   = 1'b1;
    @(posedge clk);
    #1;
    check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("accept_ready", 32'(ps2_tx_ready), 32'd0);
    check("accept_rx_en", 32'(ps2_rx_en), 32'd0);
    ps2_wr_en = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks npulse bits and samples data at the
  // end of each low phase. A full frame also gets the ACK clock with ack_bit driven.
  task automatic dev_frame(input int npulse, input bit ack_bit, input bit poke);
    bit [9:0] got = '0;
    int t = 0;
    while (!(line_clk === 1'b1 && line_data === 1'b0) && t < INH + RTS + 100) begin
      @(negedge clk);
      t++;
    end
    check("rts_seen", {30'd0, line_clk, line_data}, 32'd2);
    repeat (8) @(negedge clk);
    for (int k = 0; k < npulse && k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      got[k] = line_data;
      dev_clk_low = 1'b0;
      if (poke && k == 3) begin
        ps2_wr_data = 8'h5A;
        ps2_wr_en   = 1'b1;
        check("busy_not_ready", 32'(ps2_tx_ready), 32'd0);
        @(negedge clk);
        ps2_wr_en = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    if (npulse >= 10) begin
      obs_q.push_back(got);
      dev_data_low = ~ack_bit;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_frame(input bit [7:0] d, input bit ack_bit, input bit poke);
    exp_t e;
    e.has_frame = 1'b1;
    e.frame     = ref_frame(d);
    e.is_err    = NACK_IS_ERR && ack_bit;
    exp_q.push_back(e);
    host_write(d);
    dev_frame(10, ack_bit, poke);
    wait_drain();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t_rel;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done", 32'(ps2_tx_done), 32'd0);
    check("rst_err", 32'(ps2_tx_err), 32'd0);
    check("rst_ready", 32'(ps2_tx_ready), 32'd1);
    check("rst_rx_en", 32'(ps2_rx_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(8'hF4, 1'b0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0);

    // A write while busy must be dropped: no second frame may start.
    run_frame(8'h81, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("dropped_write_ready", 32'(ps2_tx_ready), 32'd1);
    check("dropped_write_data_oe", 32'(ps2_data_oe), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // The device NACKs.
    run_frame(8'h3C, 1'b1, 1'b0);

    // The device never clocks after RTS.
    e.has_frame = 1'b0;
    e.frame     = '0;
    e.is_err    = 1'b1;
    exp_q.push_back(e);
    host_write(8'hE6);
    t = 0;
    while (ps2_clk_oe && t < INH + RTS + 50) begin
      @(negedge clk);
      t++;
    end
    t_rel = cyc;
    t = 0;
    while (!ps2_tx_err && t < FET + 50) begin
      @(negedge clk);
      t++;
    end
    check("timeout_latency", 32'(cyc - t_rel), 32'(FET));
    wait_drain();

    // Reset at the fifth device falling edge.
    host_write(8'hA5);
    dev_frame(4, 1'b0, 1'b0);
    dev_clk_low = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("midrst_ready", 32'(ps2_tx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (BT + 50) @(negedge clk);
    check("midrst_idle_ready", 32'(ps2_tx_ready), 32'd1);

    // Transmission still works after the mid-frame reset.
    run_frame(8'h5B, 1'b0, 1'b0);

    check("final_obs_empty", 32'(obs_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
